axis_width_bridge: RTL and testbench

Parametrised AXI-Stream boundary for the neuromorphic processor. It deserialises a narrow host byte stream into full network-source words, and buffers and serialises network-sink words back onto the narrow stream with framing. It replaces the fixed byte-padded stream edges of the processor wrapper, so the processor can sit behind a UART/DMA link of any bus width.

---
 rtl/axis_width_bridge.sv | 253 +++++++++++++++++++++++++
 tb/tb_axis_width_bridge.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_width_bridge.sv
// Narrow-stream <-> network-word bridge: byte-stream deserialiser in, FIFO-buffered serialiser out.
// Latency: word valid 1 cycle after its closing beat; first out beat 1 cycle after the FIFO turns non-empty.
// Backpressure: s_axis_tready = !m_word_tvalid || m_word_tready; s_word_tready = FIFO not full; serialiser holds on !m_axis_tready.
//
// Ports:
//   clk, arstn                       clock, async active-low reset
//   s_axis_{tdata,tvalid,tlast,tready} narrow input stream (MSB-first beats, tlast closes a word early)
//   m_word_{tdata,tvalid,tready}     assembled INP_WIDTH word towards the network source
//   s_word_{tdata,tvalid,tready}     OUT_WIDTH word from the network sink into the FIFO
//   m_axis_{tdata,tvalid,tlast,tready} narrow output stream, tlast on the last beat of each word
//   short_word                       one-cycle pulse, aligned with the new m_word, when tlast closed it early
//   fifo_fill                        words held in the FIFO (the word being serialised is not counted)

// Generic FIFO: registered storage, combinational head.
// Latency: a push is visible at the head one cycle later.
// Backpressure: caller must not push when full or pop when empty.
module axis_width_bridge_fifo #(
    parameter int W     = 24,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   arstn,
    input  logic                   push_vld,
    input  logic [W-1:0]           push_dat,
    input  logic                   pop_vld,
    output logic [W-1:0]           head_dat,
    output logic [$clog2(DEPTH):0] fill,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   fill_q;

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            if (push_vld) begin
                mem_q[wr_ptr_q] <= push_dat;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_vld) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_vld && !pop_vld) begin
                fill_q <= fill_q + 1'b1;
            end else if (pop_vld && !push_vld) begin
                fill_q <= fill_q - 1'b1;
            end
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign fill     = fill_q;
    assign full     = (fill_q == FULL_CNT);
    assign empty    = (fill_q == '0);
endmodule

module axis_width_bridge #(
    parameter int BUS_WIDTH  = 8,
    parameter int INP_WIDTH  = 16,
    parameter int OUT_WIDTH  = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        arstn,
    input  logic [BUS_WIDTH-1:0]        s_axis_tdata,
    input  logic                        s_axis_tvalid,
    input  logic                        s_axis_tlast,
    output logic                        s_axis_tready,
    output logic [INP_WIDTH-1:0]        m_word_tdata,
    output logic                        m_word_tvalid,
    input  logic                        m_word_tready,
    input  logic [OUT_WIDTH-1:0]        s_word_tdata,
    input  logic                        s_word_tvalid,
    output logic                        s_word_tready,
    output logic [BUS_WIDTH-1:0]        m_axis_tdata,
    output logic                        m_axis_tvalid,
    output logic                        m_axis_tlast,
    input  logic                        m_axis_tready,
    output logic                        short_word,
    output logic [$clog2(FIFO_DEPTH):0] fifo_fill
);
    localparam int IN_BEATS  = INP_WIDTH / BUS_WIDTH;
    localparam int OUT_BEATS = OUT_WIDTH / BUS_WIDTH;
    localparam int ICW       = (IN_BEATS  > 1) ? $clog2(IN_BEATS)  : 1;
    localparam int OCW       = (OUT_BEATS > 1) ? $clog2(OUT_BEATS) : 1;
    localparam logic [ICW-1:0] IN_LAST  = ICW'(IN_BEATS - 1);
    localparam logic [OCW-1:0] OUT_LAST = OCW'(OUT_BEATS - 1);

    // ------------------------------------------------------------------
    // Deserialiser
    // ------------------------------------------------------------------
    logic [INP_WIDTH-1:0] asm_q;
    logic [INP_WIDTH-1:0] word_q;
    logic [INP_WIDTH-1:0] beat_placed;
    logic [ICW-1:0]       in_cnt_q;
    logic                 word_vld_q;
    logic                 short_q;
    logic                 in_acc;
    logic                 in_close;

    assign s_axis_tready = !word_vld_q || m_word_tready;
    assign in_acc        = s_axis_tvalid && s_axis_tready;
    assign in_close      = in_acc && (s_axis_tlast || (in_cnt_q == IN_LAST));

    // Move the beat to the top lane, then down by the beats already taken.
    always_comb begin
        beat_placed = (INP_WIDTH'(s_axis_tdata) << (INP_WIDTH - BUS_WIDTH))
                      >> (32'(in_cnt_q) * BUS_WIDTH);
    end

    // asm_q is cleared on every close, so lanes below the closing beat are
    // already zero when a word is cut short by tlast.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            asm_q      <= '0;
            word_q     <= '0;
            in_cnt_q   <= '0;
            word_vld_q <= 1'b0;
            short_q    <= 1'b0;
        end else begin
            short_q <= 1'b0;
            if (word_vld_q && m_word_tready) begin
                word_vld_q <= 1'b0;
            end
            if (in_acc) begin
                if (in_close) begin
                    word_q     <= asm_q | beat_placed;
                    word_vld_q <= 1'b1;
                    asm_q      <= '0;
                    in_cnt_q   <= '0;
                    short_q    <= (in_cnt_q != IN_LAST);
                end else begin
                    asm_q    <= asm_q | beat_placed;
                    in_cnt_q <= in_cnt_q + 1'b1;
                end
            end
        end
    end

    assign m_word_tdata  = word_q;
    assign m_word_tvalid = word_vld_q;
    assign short_word    = short_q;

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [OUT_WIDTH-1:0] fifo_head;

    assign s_word_tready = !fifo_full;
    assign fifo_push     = s_word_tvalid && !fifo_full;

    axis_width_bridge_fifo #(
        .W     (OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .arstn    (arstn),
        .push_vld (fifo_push),
        .push_dat (s_word_tdata),
        .pop_vld  (fifo_pop),
        .head_dat (fifo_head),
        .fill     (fifo_fill),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // ------------------------------------------------------------------
    // Serialiser
    // ------------------------------------------------------------------
    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } ser_state_t;

    ser_state_t           state_q;
    ser_state_t           state_nxt;
    logic [OUT_WIDTH-1:0] shreg_q;
    logic [OCW-1:0]       out_cnt_q;
    logic                 last_beat;
    logic                 shift;

    assign last_beat = (out_cnt_q == OUT_LAST);

    // A pop always loads the shift register; popping on the final accepted
    // beat keeps words back-to-back with no idle cycle between them.
    always_comb begin
        state_nxt = state_q;
        fifo_pop  = 1'b0;
        shift     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (m_axis_tready) begin
                    if (last_beat) begin
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                        end else begin
                            state_nxt = S_IDLE;
                        end
                    end else begin
                        shift = 1'b1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q <= state_nxt;
            if (fifo_pop) begin
                shreg_q   <= fifo_head;
                out_cnt_q <= '0;
            end else if (shift) begin
                shreg_q   <= shreg_q << BUS_WIDTH;
                out_cnt_q <= out_cnt_q + 1'b1;
            end else if (state_nxt == S_IDLE) begin
                out_cnt_q <= '0;
            end
        end
    end

    assign m_axis_tdata  = shreg_q[OUT_WIDTH-1 -: BUS_WIDTH];
    assign m_axis_tvalid = (state_q == S_SEND);
    assign m_axis_tlast  = (state_q == S_SEND) && last_beat;
endmodule

// File: tb/tb_axis_width_bridge.sv
module tb_axis_width_bridge;
    localparam int BW = 8;
    localparam int IW = 16;
    localparam int OW = 24;
    localparam int FD = 4;
    localparam int IN_BEATS  = IW / BW;
    localparam int OUT_BEATS = OW / BW;

    logic          clk = 1'b0;
    logic          arstn;
    logic [BW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tlast;
    logic          s_axis_tready;
    logic [IW-1:0] m_word_tdata;
    logic          m_word_tvalid;
    logic          m_word_tready;
    logic [OW-1:0] s_word_tdata;
    logic          s_word_tvalid;
    logic          s_word_tready;
    logic [BW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready;
    logic          short_word;
    logic [$clog2(FD):0] fifo_fill;

    always #5 clk = ~clk;

    axis_width_bridge #(
        .BUS_WIDTH (BW),
        .INP_WIDTH (IW),
        .OUT_WIDTH (OW),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk          (clk),
        .arstn        (arstn),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .m_word_tdata (m_word_tdata),
        .m_word_tvalid(m_word_tvalid),
        .m_word_tready(m_word_tready),
        .s_word_tdata (s_word_tdata),
        .s_word_tvalid(s_word_tvalid),
        .s_word_tready(s_word_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .short_word   (short_word),
        .fifo_fill    (fifo_fill)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0]  dat;
        logic        last;
        logic        exp_vld;
        logic [15:0] exp_word;
        logic        exp_short;
    } in_vec_t;

    in_vec_t vecs [11];

    // Reference model state for the random phase
    logic [7:0]  mdl_beats [$];
    logic [15:0] mdl_words [$];
    logic [8:0]  mdl_out   [$];   // {tlast, data}
    int          mdl_short_exp;
    int          mdl_short_seen;
    int          mdl_words_seen;
    logic        in_hold, sw_hold, ma_hold;
    logic [7:0]  ma_prev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_word_tready = 1'b1;
        s_word_tdata  = '0;
        s_word_tvalid = 1'b0;
        m_axis_tready = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_mword_vld"}, 32'(m_word_tvalid), 32'd0);
        check({tag, "_maxis_vld"}, 32'(m_axis_tvalid), 32'd0);
        check({tag, "_maxis_last"}, 32'(m_axis_tlast), 32'd0);
        check({tag, "_short"}, 32'(short_word), 32'd0);
        check({tag, "_fill"}, 32'(fifo_fill), 32'd0);
        check({tag, "_saxis_rdy"}, 32'(s_axis_tready), 32'd1);
        check({tag, "_sword_rdy"}, 32'(s_word_tready), 32'd1);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #3;
        arstn = 1'b0;
        #2;
        @(negedge clk);
        arstn = 1'b1;
        step();
    endtask

    // One random cycle: drive (respecting hold-until-accepted), then score handshakes.
    task automatic rnd_cycle(input bit drain);
        logic [15:0] w;
        logic [8:0]  exp_b;
        if (drain) begin
            idle_inputs();
        end else begin
            if (!in_hold) begin
                s_axis_tvalid = ($urandom_range(0, 3) != 0);
                s_axis_tdata  = 8'($urandom);
                s_axis_tlast  = ($urandom_range(0, 4) == 0);
            end
            if (!sw_hold) begin
                s_word_tvalid = ($urandom_range(0, 2) == 0);
                s_word_tdata  = 24'($urandom);
            end
            m_word_tready = ($urandom_range(0, 3) != 0);
            m_axis_tready = ($urandom_range(0, 3) != 0);
        end
        #1;
        check("rnd_saxis_rdy_rule", 32'(s_axis_tready), 32'(!m_word_tvalid || m_word_tready));
        if (ma_hold) begin
            check("rnd_maxis_hold", 32'({m_axis_tvalid, m_axis_tdata}), 32'({1'b1, ma_prev}));
        end
        if (short_word) mdl_short_seen++;
        if (m_word_tvalid && m_word_tready) begin
            mdl_words_seen++;
            if (mdl_words.size() == 0) begin
                check("rnd_mword_spurious", 32'd1, 32'd0);
            end else begin
                check("rnd_mword", 32'(m_word_tdata), 32'(mdl_words.pop_front()));
            end
        end
        if (s_axis_tvalid && s_axis_tready) begin
            mdl_beats.push_back(s_axis_tdata);
            if (s_axis_tlast || mdl_beats.size() == IN_BEATS) begin
                w = '0;
                for (int k = 0; k < mdl_beats.size(); k++) begin
                    w = w | (16'(mdl_beats[k]) << (IW - BW - BW * k));
                end
                if (mdl_beats.size() < IN_BEATS) mdl_short_exp++;
                mdl_words.push_back(w);
                mdl_beats.delete();
            end
        end
        if (s_word_tvalid && s_word_tready) begin
            for (int k = 0; k < OUT_BEATS; k++) begin
                mdl_out.push_back({k == OUT_BEATS - 1, 8'(s_word_tdata >> (OW - BW - BW * k))});
            end
        end
        if (m_axis_tvalid && m_axis_tready) begin
            if (mdl_out.size() == 0) begin
                check("rnd_maxis_spurious", 32'd1, 32'd0);
            end else begin
                exp_b = mdl_out.pop_front();
                check("rnd_maxis_beat", 32'({m_axis_tlast, m_axis_tdata}), 32'(exp_b));
            end
        end
        in_hold = s_axis_tvalid && !s_axis_tready;
        sw_hold = s_word_tvalid && !s_word_tready;
        ma_hold = m_axis_tvalid && !m_axis_tready;
        ma_prev = m_axis_tdata;
        step();
    endtask

    initial begin
        int acc;
        int nbeats;
        int gaps;
        int stale;
        logic [7:0] got_dat [15];
        logic       got_last [15];

        vecs[0]  = '{8'hAB, 1'b0, 1'b0, 16'h0000, 1'b0};
        vecs[1]  = '{8'hCD, 1'b0, 1'b1, 16'hABCD, 1'b0};
        vecs[2]  = '{8'h01, 1'b0, 1'b0, 16'h0000, 1'b0};
        vecs[3]  = '{8'h02, 1'b0, 1'b1, 16'h0102, 1'b0};
        vecs[4]  = '{8'h12, 1'b1, 1'b1, 16'h1200, 1'b1};
        vecs[5]  = '{8'h34, 1'b0, 1'b0, 16'h0000, 1'b0};
        vecs[6]  = '{8'h56, 1'b1, 1'b1, 16'h3456, 1'b0};
        vecs[7]  = '{8'h9A, 1'b1, 1'b1, 16'h9A00, 1'b1};
        vecs[8]  = '{8'hBC, 1'b1, 1'b1, 16'hBC00, 1'b1};
        vecs[9]  = '{8'hDE, 1'b0, 1'b0, 16'h0000, 1'b0};
        vecs[10] = '{8'hF0, 1'b0, 1'b1, 16'hDEF0, 1'b0};

        arstn = 1'b0;
        idle_inputs();
        #12;
        check_reset_values("rst0");
        @(negedge clk);
        arstn = 1'b1;
        step();

        // Deserialiser vector table, m_word_tready held high
        for (int i = 0; i < 11; i++) begin
            s_axis_tdata  = vecs[i].dat;
            s_axis_tlast  = vecs[i].last;
            s_axis_tvalid = 1'b1;
            #1;
            check($sformatf("tbl%0d_rdy", i), 32'(s_axis_tready), 32'd1);
            step();
            check($sformatf("tbl%0d_vld", i), 32'(m_word_tvalid), 32'(vecs[i].exp_vld));
            check($sformatf("tbl%0d_short", i), 32'(short_word), 32'(vecs[i].exp_short));
            if (vecs[i].exp_vld) begin
                check($sformatf("tbl%0d_word", i), 32'(m_word_tdata), 32'(vecs[i].exp_word));
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        step();

        // m_word stall holds the word and blocks the input
        m_word_tready = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 8'hAA;
        step();
        step();
        s_axis_tdata = 8'h11;
        #1;
        check("stall_saxis_rdy", 32'(s_axis_tready), 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("stall_vld", 32'(m_word_tvalid), 32'd1);
            check("stall_word", 32'(m_word_tdata), 32'hAAAA);
        end
        m_word_tready = 1'b1;
        #1;
        check("unstall_saxis_rdy", 32'(s_axis_tready), 32'd1);
        step();
        check("unstall_consumed", 32'(m_word_tvalid), 32'd0);
        s_axis_tdata = 8'h22;
        step();
        s_axis_tvalid = 1'b0;
        check("unstall_next_word", 32'(m_word_tdata), 32'h1122);

        // Single word through the serialiser
        s_word_tdata  = 24'h123456;
        s_word_tvalid = 1'b1;
        step();
        s_word_tvalid = 1'b0;
        check("ser_fill_after_push", 32'(fifo_fill), 32'd1);
        check("ser_not_yet_valid", 32'(m_axis_tvalid), 32'd0);
        step();
        check("ser_b0", 32'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}), 32'({2'b10, 8'h12}));
        step();
        check("ser_b1", 32'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}), 32'({2'b10, 8'h34}));
        step();
        check("ser_b2", 32'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}), 32'({2'b11, 8'h56}));
        step();
        check("ser_done", 32'(m_axis_tvalid), 32'd0);

        // Fill the FIFO behind a stalled serialiser, then drain back-to-back
        m_axis_tready = 1'b0;
        acc = 0;
        for (int w = 1; w <= 5; w++) begin
            s_word_tdata  = 24'(w);
            s_word_tvalid = 1'b1;
            #1;
            if (s_word_tready) acc++;
            step();
        end
        s_word_tvalid = 1'b0;
        #1;
        check("burst_accepted", 32'(acc), 32'd5);
        check("burst_fill", 32'(fifo_fill), 32'd4);
        check("burst_full_rdy", 32'(s_word_tready), 32'd0);
        m_axis_tready = 1'b1;
        nbeats = 0;
        gaps   = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (m_axis_tvalid) begin
                if (nbeats < 15) begin
                    got_dat[nbeats]  = m_axis_tdata;
                    got_last[nbeats] = m_axis_tlast;
                end
                nbeats++;
            end else if (nbeats > 0 && nbeats < 15) begin
                gaps++;
            end
            step();
        end
        check("burst_beats", 32'(nbeats), 32'd15);
        check("burst_gaps", 32'(gaps), 32'd0);
        for (int i = 0; i < 15 && i < nbeats; i++) begin
            check($sformatf("burst_beat%0d", i), 32'({got_last[i], got_dat[i]}),
                  32'({i % 3 == 2, (i % 3 == 2) ? 8'(i / 3 + 1) : 8'h00}));
        end
        check("burst_fill_end", 32'(fifo_fill), 32'd0);

        // Asynchronous reset mid-word on both paths
        s_axis_tdata  = 8'h77;
        s_axis_tvalid = 1'b1;
        step();
        s_axis_tvalid = 1'b0;
        s_word_tdata  = 24'hA1B2C3;
        s_word_tvalid = 1'b1;
        step();
        s_word_tvalid = 1'b0;
        step();
        step();
        check("pre_rst_midword", 32'({m_axis_tvalid, m_axis_tdata}), 32'({1'b1, 8'hB2}));
        #1;
        arstn = 1'b0;
        #1;
        check_reset_values("arst");
        @(negedge clk);
        arstn = 1'b1;
        step();
        stale = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 8'h88;
        stale += int'(m_axis_tvalid);
        step();
        s_axis_tdata = 8'h99;
        stale += int'(m_axis_tvalid);
        step();
        s_axis_tvalid = 1'b0;
        check("post_rst_vld", 32'(m_word_tvalid), 32'd1);
        check("post_rst_word", 32'(m_word_tdata), 32'h8899);
        for (int i = 0; i < 6; i++) begin
            stale += int'(m_axis_tvalid);
            step();
        end
        check("post_rst_no_stale", 32'(stale), 32'd0);

        // Randomized traffic against the queue model
        pulse_reset();
        mdl_beats.delete();
        mdl_words.delete();
        mdl_out.delete();
        mdl_short_exp  = 0;
        mdl_short_seen = 0;
        mdl_words_seen = 0;
        in_hold = 1'b0;
        sw_hold = 1'b0;
        ma_hold = 1'b0;
        ma_prev = '0;
        for (int c = 0; c < 3000; c++) rnd_cycle(1'b0);
        for (int c = 0; c < 60; c++) rnd_cycle(1'b1);
        check("rnd_words_left", 32'(mdl_words.size()), 32'd0);
        check("rnd_beats_left", 32'(mdl_out.size()), 32'd0);
        check("rnd_short_count", 32'(mdl_short_seen), 32'(mdl_short_exp));
        check("rnd_activity", 32'(mdl_words_seen > 100), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
